// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default width.
// ALU control and the hazard unit import the same op codes.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the unit's datapath: shift-add multiply or restoring divide,
// selected by is_div. Purely combinational; the top registers the results.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    // Multiply: hi_in is the upper accumulator, lo_in the not-yet-consumed multiplier bits.
    sum     = hi_in + (lo_in[0] ? {1'b0, opnd} : '0);
    // Divide: hi_in is the partial remainder, lo_in the dividend shifting into quotient bits.
    shifted = {hi_in[WIDTH-1:0], lo_in[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    fits    = (shifted >= {1'b0, opnd});

    if (is_div) begin
      hi_out = fits ? diff : shifted;
      lo_out = {lo_in[WIDTH-2:0], fits};
    end else begin
      hi_out = {1'b0, sum[WIDTH:1]};
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide with architectural HI/LO registers.
// Magnitudes are iterated for WIDTH cycles, then a FIX cycle applies signs and writes HI/LO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_we,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e       state;
  mdu_state_e       state_next;
  logic [CNT_W-1:0] cnt;

  logic             is_div_r;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;

  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic             done_r;
  logic             div_zero_r;

  logic             accept;
  logic             last_iter;
  logic             op_is_div;
  logic             op_is_signed;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] sx;
    sx = x;
    if (is_signed && (sx < 0)) return $unsigned(-sx);
    return x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] x,
                                                       input logic neg);
    return neg ? -x : x;
  endfunction

  assign op_is_div    = (op == MDU_DIV) || (op == MDU_DIVU);
  assign op_is_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign accept       = (state == IDLE) && start;
  assign last_iter    = (cnt == CNT_W'(WIDTH - 1));

  mdu_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div (is_div_r),
    .hi_in  (acc_hi),
    .lo_in  (acc_lo),
    .opnd   (opnd),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Sign fix-up; a zero divisor bypasses it and returns {HI, LO} = {a, all-ones}.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    prod   = cond_neg_wide({acc_hi[WIDTH-1:0], acc_lo}, neg_q);
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div_r) begin
      if (b_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = cond_neg(acc_hi[WIDTH-1:0], neg_r);
        fix_lo = cond_neg(acc_lo, neg_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      is_div_r   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      b_zero     <= 1'b0;
      a_raw      <= '0;
      opnd       <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r <= (state == FIX);

      if (accept) begin
        is_div_r   <= op_is_div;
        neg_q      <= op_is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r      <= op_is_signed & a[WIDTH-1];
        b_zero     <= (b == '0);
        a_raw      <= a;
        acc_hi     <= '0;
        // Divide iterates the dividend through acc_lo; multiply iterates the multiplier.
        acc_lo     <= op_is_div ? magnitude(a, op_is_signed) : magnitude(b, op_is_signed);
        opnd       <= op_is_div ? magnitude(b, op_is_signed) : magnitude(a, op_is_signed);
        cnt        <= '0;
        div_zero_r <= 1'b0;
      end else if (state == RUN) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt + CNT_W'(1);
      end

      if (state == FIX) begin
        hi_r       <= fix_hi;
        lo_r       <= fix_lo;
        div_zero_r <= is_div_r & b_zero;
      end else if ((state == IDLE) && mt_we && !start) begin
        if (mt_sel) hi_r <= mt_data;
        else        lo_r <= mt_data;
      end
    end
  end

  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit with the architectural HI/LO registers. It sits beside the ALU in the execute stage and consumes the decoded mult/div operation produced by ALU control. Signed/unsigned 32x32 multiply (64-bit product) and 32/32 divide (quotient and remainder) complete in a fixed number of cycles. HI/LO are exposed directly for mfhi/mflo, and the block asserts busy so the pipeline can stall.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a new operation; honoured only in IDLE.
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
a  input  WIDTH  rs operand: multiplicand or dividend.
b  input  WIDTH  rt operand: multiplier or divisor.
mt_we  input  1  mthi/mtlo write strobe; honoured only in IDLE.
mt_sel  input  1  0 = write LO, 1 = write HI.
mt_data  input  WIDTH  data for mthi/mtlo.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse when HI/LO take the new result.
div_zero  output  1  sticky flag; set by a divide with b == 0, cleared by the next accepted start.
hi  output  WIDTH  HI register (mfhi source).
lo  output  WIDTH  LO register (mflo source).

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; hi, lo, busy, done, div_zero, counter and internal registers all return to 0. Reset mid-operation abandons it; HI/LO read 0 and no done pulse follows.
- States: IDLE, RUN, FIX.
- IDLE, start = 1 at edge E0:
  - latch |a| and |b| (two's-complement magnitude for signed ops; raw values for unsigned ops);
  - latch op, neg_q = a[msb] ^ b[msb] and neg_r = a[msb] (signed ops only; 0 for unsigned);
  - counter = 0, go to RUN, clear div_zero.
- RUN: one iteration per edge, on edges E1..E32 (WIDTH iterations).
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle. Remainder register is WIDTH+1 bits so subtract/compare is unsigned.
  - After iteration WIDTH, go to FIX.
- FIX, edge E33:
  - apply sign fix-up: negate the product if neg_q; negate the quotient if neg_q; negate the remainder if neg_r;
  - write HI = product[63:32] / remainder and LO = product[31:0] / quotient;
  - return to IDLE.
- done is high for exactly the cycle after E33. busy is high in the cycles after E0..E32 (33 cycles) and low in the done cycle.
- Total latency: start edge to result visible on hi/lo is 33 edges.
- Divide by zero (b == 0 at accept):
  - the operation still takes the full 33 edges;
  - result is LO = all-ones, HI = a (the original value); sign fix-up is skipped;
  - div_zero is set at E33.
- Signed divide of 0x80000000 by -1: magnitudes give 0x80000000 / 1; after negation LO = 0x80000000, HI = 0. No trap.
- start while busy is ignored; operands are not re-latched.
- start asserted in the done cycle is accepted, so back-to-back operations are possible.
- mt_we in IDLE writes the selected register at that edge.
- mt_we while busy is ignored.
- mt_we and start on the same IDLE edge: start wins and the mt write is dropped.
- hi/lo change only at FIX, on an mt write, or on reset. They hold stable throughout RUN.

Decomposition:
- Shared package mdu_pkg: op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), state enum (IDLE/RUN/FIX) and WIDTH default.
- ALU control and the hazard unit import the same op codes.
- One natural sub-module, mdu_iter_step: combinational single-iteration datapath for shift-add and restore-subtract, selected by an is_div input. FSM, counter and HI/LO registers stay in the top.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> done in the cycle after E33; HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy high for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678, div_zero=1; the next accepted start clears div_zero.
- start pulsed at E10 of a running op, and mt_we during RUN -> both ignored, result unchanged; start in the done cycle begins the next op with busy staying low only in that cycle; mt_we (sel=1, 0xCAFEF00D) in IDLE -> hi=0xCAFEF00D next cycle.
- rst_n driven low asynchronously mid-RUN (between edges) -> hi, lo, busy, done immediately 0 and no done pulse after release; same-edge start+mt_we in IDLE -> operation runs and the mt write is lost.
